ws_mac_pe: RTL and testbench

Weight-stationary processing element for the systolic array. It multiplies a streaming activation by a locally held weight and adds the product to the partial sum arriving from the PE above. Unlike the single-register PE, weights are double-buffered: a shadow weight shifts down the column while the active weight keeps computing, so the array can preload the next tile with no stall. The block also adds valid tagging, runtime signed/unsigned selection, optional saturation and a sticky overflow flag.

---
 rtl/ws_mac_pe_if.sv | 48 ++++
 rtl/ws_mac_pe.sv | 161 ++++++++++++++++
 tb/tb_ws_mac_pe.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ws_mac_pe_if.sv
// ws_mac_pe_if: bundle of the activation, partial-sum, weight-chain, mode and
// overflow signals of one weight-stationary MAC processing element.
//   master : the neighbourhood driving the PE (west/north sources, control)
//   slave  : the PE itself
// Signals:
//   data_in/data_valid_in     activation from the west and its qualifier
//   data_out/data_valid_out   registered activation and qualifier to the east
//   acc_in/acc_valid_in       partial sum from the north and its qualifier
//   acc_out/acc_valid_out     registered partial sum and qualifier to the south
//   wt_path_in/wt_path_out    weight chain (north in, shadow weight south out)
//   wt_load/wt_swap           shadow load / shadow-to-active transfer
//   sign_mode/sat_en          two's-complement select / saturation enable
//   ovf_clr/ovf_flag          sticky overflow clear / indicator
interface ws_mac_pe_if #(
    parameter int bit_width = 8,
    parameter int acc_width = 16
);
    logic [bit_width-1:0] data_in;
    logic                 data_valid_in;
    logic [bit_width-1:0] data_out;
    logic                 data_valid_out;
    logic [acc_width-1:0] acc_in;
    logic                 acc_valid_in;
    logic [acc_width-1:0] acc_out;
    logic                 acc_valid_out;
    logic [bit_width-1:0] wt_path_in;
    logic [bit_width-1:0] wt_path_out;
    logic                 wt_load;
    logic                 wt_swap;
    logic                 sign_mode;
    logic                 sat_en;
    logic                 ovf_clr;
    logic                 ovf_flag;

    modport master (
        output data_in, data_valid_in, acc_in, acc_valid_in, wt_path_in,
               wt_load, wt_swap, sign_mode, sat_en, ovf_clr,
        input  data_out, data_valid_out, acc_out, acc_valid_out, wt_path_out,
               ovf_flag
    );

    modport slave (
        input  data_in, data_valid_in, acc_in, acc_valid_in, wt_path_in,
               wt_load, wt_swap, sign_mode, sat_en, ovf_clr,
        output data_out, data_valid_out, acc_out, acc_valid_out, wt_path_out,
               ovf_flag
    );
endinterface

// File: rtl/ws_mac_pe.sv
// ws_mac_pe: weight-stationary MAC processing element with a double-buffered
// weight. A shadow weight shifts down the column on wt_load while the active
// weight keeps multiplying; wt_swap moves the shadow into the active slot.
// acc_out = acc_in + (data_valid_in ? data_in * active_wt : 0), registered,
// with runtime signed/unsigned operands, optional saturation and a sticky
// overflow flag.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears every register
//   bus   : ws_mac_pe_if slave modport (see interface for signal list)
module ws_mac_pe #(
    parameter int bit_width = 8,
    parameter int acc_width = 16
) (
    input  logic        clk,
    input  logic        reset,
    ws_mac_pe_if.slave  bus
);
    localparam int prod_width = 2 * bit_width;
    localparam int sum_width  = acc_width + 1;

    generate
        if (acc_width < 2 * bit_width) begin : g_width_check
            $error("ws_mac_pe: acc_width must be at least 2*bit_width");
        end
    endgenerate

    // Clamp value for an overflowing result: signed max/min by true-sum sign,
    // or the all-ones unsigned max.
    function automatic logic [acc_width-1:0] sat_value(
        input logic signed_mode,
        input logic negative
    );
        logic [acc_width-1:0] val;
        if (signed_mode) begin
            if (negative) begin
                val = {1'b1, {(acc_width-1){1'b0}}};
            end else begin
                val = {1'b0, {(acc_width-1){1'b1}}};
            end
        end else begin
            val = {acc_width{1'b1}};
        end
        return val;
    endfunction

    logic [bit_width-1:0]  shadow_wt_r;
    logic [bit_width-1:0]  active_wt_r;
    logic [bit_width-1:0]  data_out_r;
    logic                  data_valid_out_r;
    logic [acc_width-1:0]  acc_out_r;
    logic                  acc_valid_out_r;
    logic                  ovf_flag_r;

    logic signed [prod_width-1:0] prod_sgn_s;
    logic [prod_width-1:0]        prod_uns_s;
    logic [sum_width-1:0]         prod_ext_s;
    logic [sum_width-1:0]         acc_ext_s;
    logic [sum_width-1:0]         addend_s;
    logic [sum_width-1:0]         sum_s;
    logic                         ovf_s;
    logic [acc_width-1:0]         result_s;

    // Operands are widened to the full product width first so the truncated
    // product is exact for both signed and unsigned interpretations.
    assign prod_sgn_s = $signed({{bit_width{bus.data_in[bit_width-1]}}, bus.data_in})
                      * $signed({{bit_width{active_wt_r[bit_width-1]}}, active_wt_r});
    assign prod_uns_s = {{bit_width{1'b0}}, bus.data_in}
                      * {{bit_width{1'b0}}, active_wt_r};

    // Extend product and incoming partial sum to acc_width+1 bits and add.
    always_comb begin
        prod_ext_s = {sum_width{1'b0}};
        if (bus.sign_mode) begin
            prod_ext_s = {{(sum_width-prod_width){prod_sgn_s[prod_width-1]}}, prod_sgn_s};
        end else begin
            prod_ext_s = {{(sum_width-prod_width){1'b0}}, prod_uns_s};
        end
        acc_ext_s = {bus.sign_mode & bus.acc_in[acc_width-1], bus.acc_in};
        if (bus.data_valid_in) begin
            addend_s = prod_ext_s;
        end else begin
            addend_s = {sum_width{1'b0}};
        end
        sum_s = acc_ext_s + addend_s;
    end

    // Overflow only counts when both operands are valid. The extra sum bit
    // holds the true sign (signed) or the carry out (unsigned).
    always_comb begin
        ovf_s = 1'b0;
        if (bus.data_valid_in & bus.acc_valid_in) begin
            if (bus.sign_mode) begin
                ovf_s = sum_s[sum_width-1] ^ sum_s[sum_width-2];
            end else begin
                ovf_s = sum_s[sum_width-1];
            end
        end else begin
            ovf_s = 1'b0;
        end
    end

    // Saturate on overflow when enabled, otherwise wrap to acc_width bits.
    always_comb begin
        result_s = sum_s[acc_width-1:0];
        if (bus.sat_en & ovf_s) begin
            result_s = sat_value(bus.sign_mode, sum_s[sum_width-1]);
        end else begin
            result_s = sum_s[acc_width-1:0];
        end
    end

    // Double-buffered weights: swap takes the pre-edge shadow, so load and
    // swap in one cycle move old shadow to active and new value to shadow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_wt_r <= {bit_width{1'b0}};
            active_wt_r <= {bit_width{1'b0}};
        end else begin
            if (bus.wt_load) begin
                shadow_wt_r <= bus.wt_path_in;
            end
            if (bus.wt_swap) begin
                active_wt_r <= shadow_wt_r;
            end
        end
    end

    // Data/partial-sum pipeline stage registered every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_r       <= {bit_width{1'b0}};
            data_valid_out_r <= 1'b0;
            acc_out_r        <= {acc_width{1'b0}};
            acc_valid_out_r  <= 1'b0;
        end else begin
            data_out_r       <= bus.data_in;
            data_valid_out_r <= bus.data_valid_in;
            acc_out_r        <= result_s;
            acc_valid_out_r  <= bus.acc_valid_in;
        end
    end

    // Sticky overflow flag; a new overflow wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_flag_r <= 1'b0;
        end else if (ovf_s) begin
            ovf_flag_r <= 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_flag_r <= 1'b0;
        end
    end

    assign bus.data_out       = data_out_r;
    assign bus.data_valid_out = data_valid_out_r;
    assign bus.acc_out        = acc_out_r;
    assign bus.acc_valid_out  = acc_valid_out_r;
    assign bus.wt_path_out    = shadow_wt_r;
    assign bus.ovf_flag       = ovf_flag_r;
endmodule

// File: tb/tb_ws_mac_pe.sv
// tb_ws_mac_pe: scoreboard bench for ws_mac_pe. Stimulus computes the
// expected registered outputs from an arithmetic model and queues them; a
// monitor pops one entry after each rising edge and compares.
module tb_ws_mac_pe;
    localparam int BW = 8;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ws_mac_pe_if #(.bit_width(BW), .acc_width(AW)) bus();

    ws_mac_pe #(.bit_width(BW), .acc_width(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [15:0] acc;
        logic        accv;
        logic [7:0]  data;
        logic        dv;
        logic        ovf;
        logic [7:0]  wpo;
        int          gacc;
        int          govf;
    } exp_t;

    exp_t sb_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_shadow;
    logic [7:0] m_active;
    logic       m_flag;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic longint sx8(input logic [7:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint sx16(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    // One cycle of stimulus; gacc/govf are optional hand-derived gold values.
    task automatic step(input logic [7:0] d, input logic dv, input logic [15:0] a,
                        input logic av, input logic [7:0] wp, input logic ld,
                        input logic sw, input logic sm, input logic se,
                        input logic clr, input int gacc = -1, input int govf = -1);
        longint prod, accv, tsum;
        logic ovf;
        exp_t e;
        @(negedge clk);
        bus.data_in = d; bus.data_valid_in = dv;
        bus.acc_in = a;  bus.acc_valid_in = av;
        bus.wt_path_in = wp; bus.wt_load = ld; bus.wt_swap = sw;
        bus.sign_mode = sm; bus.sat_en = se; bus.ovf_clr = clr;
        prod = sm ? sx8(d) * sx8(m_active) : longint'(d) * longint'(m_active);
        accv = sm ? sx16(a) : longint'(a);
        tsum = accv + (dv ? prod : 64'sd0);
        ovf  = dv && av && (sm ? (tsum > 32767 || tsum < -32768) : (tsum > 65535));
        if (se && ovf) e.acc = sm ? ((tsum < 0) ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
        else           e.acc = tsum[15:0];
        e.accv = av; e.data = d; e.dv = dv;
        e.ovf  = ovf ? 1'b1 : (clr ? 1'b0 : m_flag);
        e.wpo  = ld ? wp : m_shadow;
        e.gacc = gacc; e.govf = govf;
        m_flag = e.ovf;
        if (sw) m_active = m_shadow;
        if (ld) m_shadow = wp;
        sb_q.push_back(e);
    endtask

    // Monitor: compare one expected entry per rising edge.
    exp_t mon_e;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("acc_out", bus.acc_out, mon_e.acc);
                check("acc_valid_out", bus.acc_valid_out, mon_e.accv);
                check("data_out", bus.data_out, mon_e.data);
                check("data_valid_out", bus.data_valid_out, mon_e.dv);
                check("ovf_flag", bus.ovf_flag, mon_e.ovf);
                check("wt_path_out", bus.wt_path_out, mon_e.wpo);
                if (mon_e.gacc >= 0) check("acc_gold", bus.acc_out, mon_e.gacc);
                if (mon_e.govf >= 0) check("ovf_gold", bus.ovf_flag, mon_e.govf);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_acc_out"}, bus.acc_out, 0);
        check({tag, "_acc_valid_out"}, bus.acc_valid_out, 0);
        check({tag, "_data_out"}, bus.data_out, 0);
        check({tag, "_data_valid_out"}, bus.data_valid_out, 0);
        check({tag, "_ovf_flag"}, bus.ovf_flag, 0);
        check({tag, "_wt_path_out"}, bus.wt_path_out, 0);
    endtask

    logic sm_r;
    logic se_r;

    initial begin
        reset = 1'b0;
        bus.data_in = 8'd0; bus.data_valid_in = 1'b0;
        bus.acc_in = 16'd0; bus.acc_valid_in = 1'b0;
        bus.wt_path_in = 8'd0; bus.wt_load = 1'b0; bus.wt_swap = 1'b0;
        bus.sign_mode = 1'b0; bus.sat_en = 1'b0; bus.ovf_clr = 1'b0;
        m_shadow = 8'd0; m_active = 8'd0; m_flag = 1'b0;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Unsigned MAC: 250 * 200 = 50000
        step(8'd0, 1'b0, 16'd0, 1'b0, 8'd200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(8'd0, 1'b0, 16'd0, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'd250, 1'b1, 16'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 50000, 0);

        // Signed MAC: -3 * 100 + 5 = -295
        step(8'd0, 1'b0, 16'd0, 1'b0, 8'hFD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(8'd0, 1'b0, 16'd0, 1'b0, 8'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(8'd100, 1'b1, 16'd5, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFED9, 0);

        // Double buffer: active 3, stream 2, preload 5
        step(8'd0, 1'b0, 16'd0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(8'd0, 1'b0, 16'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'd2, 1'b1, 16'd0, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6);
        step(8'd2, 1'b1, 16'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6);
        step(8'd2, 1'b1, 16'd0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6);
        step(8'd2, 1'b1, 16'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        step(8'd2, 1'b1, 16'd0, 1'b1, 8'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        step(8'd2, 1'b1, 16'd0, 1'b1, 8'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10);
        step(8'd2, 1'b1, 16'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18);

        // Saturation and wrap, signed then unsigned
        step(8'd0, 1'b0, 16'd0, 1'b0, 8'd127, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(8'd0, 1'b0, 16'd0, 1'b0, 8'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(8'd127, 1'b1, 16'h7FF0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h7FFF, 1);
        step(8'd127, 1'b1, 16'h7FF0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEF1, 1);
        step(8'd0, 1'b0, 16'd0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(8'd0, 1'b0, 16'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'h20, 1'b1, 16'hFFF0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1);

        // Valid gating, flag clear, set-wins-over-clear
        step(8'h55, 1'b0, 16'h1234, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 1);
        step(8'd0, 1'b0, 16'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
        step(8'h20, 1'b1, 16'hFFF0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 1);

        // Asynchronous reset between edges while streaming
        step(8'd3, 1'b1, 16'h0100, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        m_shadow = 8'd0; m_active = 8'd0; m_flag = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(8'h33, 1'b1, 16'h0421, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0421, 0);

        // Randomized traffic; modes change only every 40 cycles
        sm_r = 1'b0; se_r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i % 40 == 0) begin
                sm_r = 1'($urandom_range(0, 1));
                se_r = 1'($urandom_range(0, 1));
            end
            step(8'($urandom), 1'($urandom_range(0, 3) != 0), 16'($urandom),
                 1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0),
                 sm_r, se_r, 1'($urandom_range(0, 7) == 0));
        end

        repeat (2) @(posedge clk);
        #2;
        check("queue_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
